// File: rtl/d8m_seq_pkg.sv
// Shared types and constants for the D8M camera bring-up sequencer.
// Holds the FSM state encoding, ROM entry layout and timer width.
package d8m_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWDN,
    ST_RST,
    ST_WAKE,
    ST_FETCH,
    ST_DECODE,
    ST_I2C_WR,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [15:0] DLY_MARK  = 16'hFFFE;
  localparam int unsigned US_PER_MS = 1000;
  localparam int unsigned TMR_W     = 25;

  typedef struct packed {
    logic [15:0] reg_addr;
    logic [7:0]  reg_data;
  } rom_entry_t;

  // Millisecond delay entries are counted by the microsecond timer.
  function automatic logic [TMR_W-1:0] ms_to_us(input logic [7:0] ms);
    return TMR_W'(ms) * TMR_W'(US_PER_MS);
  endfunction

endpackage

// File: rtl/d8m_us_timer.sv
// Microsecond down-counter: a clk prescaler produces 1 us ticks that decrement
// a loadable count. Loading restarts the prescaler so every interval is exact.
module d8m_us_timer
  import d8m_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_us,
  output logic             expired
);

  localparam int unsigned DIV      = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]    r_pre;
  logic [TMR_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_pre <= '0;
      r_cnt <= load_us;
    end else if (r_cnt != '0) begin
      if (w_tick) begin
        r_pre <= '0;
        r_cnt <= r_cnt - TMR_W'(1);
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // Flags the last cycle of the interval so the owner leaves exactly on time.
  assign expired = (r_cnt == '0) || ((r_cnt == TMR_W'(1)) && w_tick);

endmodule

// File: rtl/d8m_bringup_seq.sv
// D8M camera power-up sequencer: times the pwdn/reset/XCLK pins, then walks
// a config ROM issuing I2C register writes with NACK retry.
module d8m_bringup_seq
  import d8m_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned PWDN_US   = 1000,
  parameter int unsigned RST_US    = 1000,
  parameter int unsigned WAKE_US   = 20000,
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [6:0]  DEV_ADDR  = 7'h0E
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              i2c_req,
  output logic [6:0]        i2c_dev,
  output logic [15:0]       i2c_reg,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_ack,
  input  logic              i2c_nack,
  output logic              mipi_pwdn_n,
  output logic              mipi_reset_n,
  output logic              xclk_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned       RTY_W    = $clog2(MAX_RETRY + 2);
  localparam logic [ROM_AW-1:0] LAST_IDX = {ROM_AW{1'b1}};
  localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

  seq_state_t        r_state,    w_state_nxt;
  logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic              r_req,      w_req_nxt;
  logic [6:0]        r_dev,      w_dev_nxt;
  logic [15:0]       r_reg,      w_reg_nxt;
  logic [7:0]        r_wdata,    w_wdata_nxt;
  logic              r_pwdn_n,   w_pwdn_n_nxt;
  logic              r_reset_n,  w_reset_n_nxt;
  logic              r_xclk,     w_xclk_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_error,    w_error_nxt;
  logic [ROM_AW-1:0] r_err_idx,  w_err_idx_nxt;
  logic [RTY_W-1:0]  r_retry,    w_retry_nxt;
  logic              r_armed;

  rom_entry_t        w_entry;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_us;
  logic              w_tmr_expired;
  logic              w_advance;

  assign w_entry = rom_entry_t'(rom_data);

  d8m_us_timer #(
    .CLK_HZ (CLK_HZ)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_tmr_load),
    .load_us (w_tmr_us),
    .expired (w_tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_req      <= 1'b0;
      r_dev      <= '0;
      r_reg      <= '0;
      r_wdata    <= '0;
      r_pwdn_n   <= 1'b0;
      r_reset_n  <= 1'b0;
      r_xclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_idx  <= '0;
      r_retry    <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_req      <= w_req_nxt;
      r_dev      <= w_dev_nxt;
      r_reg      <= w_reg_nxt;
      r_wdata    <= w_wdata_nxt;
      r_pwdn_n   <= w_pwdn_n_nxt;
      r_reset_n  <= w_reset_n_nxt;
      r_xclk     <= w_xclk_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_err_idx  <= w_err_idx_nxt;
      r_retry    <= w_retry_nxt;
      // Blocks a start pulse that lands on the first edge after reset release.
      r_armed    <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rom_addr_nxt = r_rom_addr;
    w_req_nxt      = r_req;
    w_dev_nxt      = r_dev;
    w_reg_nxt      = r_reg;
    w_wdata_nxt    = r_wdata;
    w_pwdn_n_nxt   = r_pwdn_n;
    w_reset_n_nxt  = r_reset_n;
    w_xclk_nxt     = r_xclk;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_err_idx_nxt  = r_err_idx;
    w_retry_nxt    = r_retry;
    w_tmr_load     = 1'b0;
    w_tmr_us       = '0;
    w_advance      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start && r_armed) begin
          w_state_nxt    = ST_PWDN;
          w_busy_nxt     = 1'b1;
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
          w_xclk_nxt     = 1'b1;
          w_pwdn_n_nxt   = 1'b0;
          w_reset_n_nxt  = 1'b0;
          w_rom_addr_nxt = '0;
          w_dev_nxt      = DEV_ADDR;
          w_tmr_load     = 1'b1;
          w_tmr_us       = TMR_W'(PWDN_US);
        end
      end

      ST_PWDN: begin
        if (w_tmr_expired) begin
          w_pwdn_n_nxt = 1'b1;
          w_tmr_load   = 1'b1;
          w_tmr_us     = TMR_W'(RST_US);
          w_state_nxt  = ST_RST;
        end
      end

      ST_RST: begin
        if (w_tmr_expired) begin
          w_reset_n_nxt = 1'b1;
          w_tmr_load    = 1'b1;
          w_tmr_us      = TMR_W'(WAKE_US);
          w_state_nxt   = ST_WAKE;
        end
      end

      ST_WAKE: begin
        if (w_tmr_expired) begin
          w_state_nxt = ST_FETCH;
        end
      end

      // One cycle for the synchronous ROM to present the addressed entry.
      ST_FETCH: begin
        w_state_nxt = ST_DECODE;
      end

      ST_DECODE: begin
        w_retry_nxt = '0;
        if (w_entry.reg_addr == END_MARK) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (w_entry.reg_addr == DLY_MARK) begin
          if (w_entry.reg_data == 8'h00) begin
            w_advance = 1'b1;
          end else begin
            w_tmr_load  = 1'b1;
            w_tmr_us    = ms_to_us(w_entry.reg_data);
            w_state_nxt = ST_DELAY;
          end
        end else begin
          w_req_nxt   = 1'b1;
          w_reg_nxt   = w_entry.reg_addr;
          w_wdata_nxt = w_entry.reg_data;
          w_state_nxt = ST_I2C_WR;
        end
      end

      // req low here means the one-cycle gap after a NACK; raise it again.
      ST_I2C_WR: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
        end else if (i2c_ack) begin
          w_req_nxt = 1'b0;
          if (!i2c_nack) begin
            w_advance = 1'b1;
          end else if (r_retry >= RTY_MAX) begin
            w_state_nxt   = ST_ERROR;
            w_busy_nxt    = 1'b0;
            w_error_nxt   = 1'b1;
            w_err_idx_nxt = r_rom_addr;
          end else begin
            w_retry_nxt = r_retry + RTY_W'(1);
          end
        end
      end

      ST_DELAY: begin
        if (w_tmr_expired) begin
          w_advance = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Finishing the last ROM slot ends the table rather than wrapping to 0.
    if (w_advance) begin
      if (r_rom_addr == LAST_IDX) begin
        w_state_nxt = ST_DONE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end else begin
        w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
        w_state_nxt    = ST_FETCH;
      end
    end
  end

  assign rom_addr     = r_rom_addr;
  assign i2c_req      = r_req;
  assign i2c_dev      = r_dev;
  assign i2c_reg      = r_reg;
  assign i2c_wdata    = r_wdata;
  assign mipi_pwdn_n  = r_pwdn_n;
  assign mipi_reset_n = r_reset_n;
  assign xclk_en      = r_xclk;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_index    = r_err_idx;

endmodule
